// File: rtl/crossfade_mixer_if.sv
// Audio-side bundle of the dry/wet crossfade stage: sample strobe, bypass
// request, both stereo sources in, and the mixed stereo result with status out.
interface crossfade_mixer_if #(
   parameter int DATA_WIDTH = 24,
   parameter int GAIN_BITS  = 8
);
   logic                         sample_en;
   logic                         bypass;
   logic signed [DATA_WIDTH-1:0] dry_l;
   logic signed [DATA_WIDTH-1:0] dry_r;
   logic signed [DATA_WIDTH-1:0] wet_l;
   logic signed [DATA_WIDTH-1:0] wet_r;
   logic signed [DATA_WIDTH-1:0] mix_l;
   logic signed [DATA_WIDTH-1:0] mix_r;
   logic                         mix_valid;
   logic                         fading;
   logic [GAIN_BITS:0]           gain;

   modport master (
      output sample_en, bypass, dry_l, dry_r, wet_l, wet_r,
      input  mix_l, mix_r, mix_valid, fading, gain
   );

   modport slave (
      input  sample_en, bypass, dry_l, dry_r, wet_l, wet_r,
      output mix_l, mix_r, mix_valid, fading, gain
   );
endinterface

// File: rtl/crossfade_mixer.sv
// Click-free dry/wet output stage: linear gain ramp of one step per sample
// strobe, followed by a 3-stage multiply/add/floor-shift stereo mix pipeline.
module crossfade_mixer #(
   parameter int DATA_WIDTH = 24,
   parameter int GAIN_BITS  = 8,
   parameter int RESET_WET  = 1
) (
   input  logic                clk,
   input  logic                rstn,
   crossfade_mixer_if.slave    bus
);

   localparam int PW = DATA_WIDTH + GAIN_BITS + 2;
   localparam logic [GAIN_BITS:0] G_MAX = {1'b1, {GAIN_BITS{1'b0}}};
   localparam logic [GAIN_BITS:0] G_ONE = (GAIN_BITS + 1)'(1);
   localparam logic [GAIN_BITS:0] G_RST = (RESET_WET != 0) ? G_MAX : '0;

   typedef enum logic [1:0] {DRY, TO_WET, WET, TO_DRY} state_t;
   localparam state_t S_RST = (RESET_WET != 0) ? WET : DRY;

   state_t             state_q, state_d;
   logic [GAIN_BITS:0] gain_q, gain_d;
   logic               fading_q;

   logic signed [DATA_WIDTH-1:0] dry_l_p0, dry_r_p0, wet_l_p0, wet_r_p0;
   logic [GAIN_BITS:0]           g_p0;
   logic                         vld_p0;
   logic signed [PW-1:0]         pw_l_p1, pd_l_p1, pw_r_p1, pd_r_p1;
   logic                         vld_p1;
   logic signed [DATA_WIDTH-1:0] mix_l_p2, mix_r_p2;
   logic                         vld_p2;

   logic signed [PW-1:0] gw_x, gd_x;

   function automatic logic signed [PW-1:0] sext(input logic signed [DATA_WIDTH-1:0] x);
      return signed'({{(PW - DATA_WIDTH){x[DATA_WIDTH-1]}}, x});
   endfunction

   // Arithmetic shift gives floor rounding; a convex combination never overflows.
   function automatic logic signed [DATA_WIDTH-1:0] floor_shift(input logic signed [PW-1:0] s);
      return DATA_WIDTH'(s >>> GAIN_BITS);
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_RST;
         gain_q   <= G_RST;
         fading_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gain_q   <= gain_d;
         fading_q <= (state_d == TO_WET) || (state_d == TO_DRY);
      end
   end

   // Reversals keep the current gain; the clamps also cover a reversal taken at an endpoint.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (bus.sample_en) begin
         case (state_q)
            DRY: begin
               if (!bus.bypass) state_d = TO_WET;
            end
            TO_WET: begin
               if (bus.bypass) begin
                  state_d = TO_DRY;
               end else if (gain_q >= G_MAX - G_ONE) begin
                  gain_d  = G_MAX;
                  state_d = WET;
               end else begin
                  gain_d = gain_q + G_ONE;
               end
            end
            WET: begin
               if (bus.bypass) state_d = TO_DRY;
            end
            TO_DRY: begin
               if (!bus.bypass) begin
                  state_d = TO_WET;
               end else if (gain_q <= G_ONE) begin
                  gain_d  = '0;
                  state_d = DRY;
               end else begin
                  gain_d = gain_q - G_ONE;
               end
            end
            default: begin
               state_d = S_RST;
               gain_d  = G_RST;
            end
         endcase
      end
   end

   assign gw_x = signed'(PW'(g_p0));
   assign gd_x = signed'(PW'(G_MAX - g_p0));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_p0   <= 1'b0;
         dry_l_p0 <= '0;
         dry_r_p0 <= '0;
         wet_l_p0 <= '0;
         wet_r_p0 <= '0;
         g_p0     <= '0;
         vld_p1   <= 1'b0;
         pw_l_p1  <= '0;
         pd_l_p1  <= '0;
         pw_r_p1  <= '0;
         pd_r_p1  <= '0;
         vld_p2   <= 1'b0;
         mix_l_p2 <= '0;
         mix_r_p2 <= '0;
      end else begin
         // E0: capture samples with the gain in force before this edge's update
         vld_p0 <= bus.sample_en;
         if (bus.sample_en) begin
            dry_l_p0 <= bus.dry_l;
            dry_r_p0 <= bus.dry_r;
            wet_l_p0 <= bus.wet_l;
            wet_r_p0 <= bus.wet_r;
            g_p0     <= gain_q;
         end
         // E1: weighted products
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            pw_l_p1 <= sext(wet_l_p0) * gw_x;
            pd_l_p1 <= sext(dry_l_p0) * gd_x;
            pw_r_p1 <= sext(wet_r_p0) * gw_x;
            pd_r_p1 <= sext(dry_r_p0) * gd_x;
         end
         // E2: sum and rescale; result is held until the next sample
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            mix_l_p2 <= floor_shift(pw_l_p1 + pd_l_p1);
            mix_r_p2 <= floor_shift(pw_r_p1 + pd_r_p1);
         end
      end
   end

   assign bus.mix_l     = mix_l_p2;
   assign bus.mix_r     = mix_r_p2;
   assign bus.mix_valid = vld_p2;
   assign bus.fading    = fading_q;
   assign bus.gain      = gain_q;

endmodule
